data_mem_responder: RTL

Memory-side responder for the core's load/store requests. It accepts one request (address, funct3 access pattern, store data) over a valid/ready handshake and drives a word-wide data memory with byte enables. It waits for the memory acknowledge, then aligns and sign- or zero-extends load data. It returns the result, or an error for misaligned, illegal or timed-out accesses, over a valid/ready response handshake.

---
 rtl/data_mem_responder_pkg.sv | 51 +++++
 rtl/data_mem_responder_if.sv | 36 +++
 rtl/data_mem_responder_load_extend.sv | 39 +++
 rtl/data_mem_responder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared load/store encodings, responder states and request helpers
package data_mem_responder_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  localparam logic [2:0] OP_SB = 3'b000;
  localparam logic [2:0] OP_SH = 3'b001;
  localparam logic [2:0] OP_SW = 3'b010;

  typedef enum logic [1:0] {IDLE, MEM, RESP} resp_state_e;

  function automatic logic req_error(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (we) illegal = !(funct3 inside {OP_SB, OP_SH, OP_SW});
    else    illegal = !(funct3 inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

  function automatic logic [3:0] calc_be(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    if (!we) return 4'b1111;
    case (funct3[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across lanes so the byte enables pick the right copy.
  function automatic logic [31:0] calc_wdata(input logic we, input logic [2:0] funct3,
                                             input logic [31:0] wdata);
    if (!we) return 32'h0;
    case (funct3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response and data memory bus bundle
interface data_mem_responder_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_req;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-3:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/data_mem_responder_load_extend.sv
// rtl/data_mem_responder_load_extend.sv - selects the load lane and sign/zero-extends it
module data_mem_responder_load_extend
  import data_mem_responder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      OP_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      OP_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      OP_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - accepts one load/store, drives the data memory, returns data or error
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input logic                 CLK,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  resp_state_e     r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [3:0]      r_mem_be;
  logic [XLEN-3:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic            r_resp_valid;
  logic            r_resp_err;
  logic [XLEN-1:0] r_resp_rdata;
  logic            w_req_err;
  logic [XLEN-1:0] w_load_data;

  assign w_req_err = req_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  data_mem_responder_load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_word    (bus.mem_rdata),
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .o_data    (w_load_data)
  );

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_be     = r_mem_be;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'b0000;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_funct3    <= bus.req_funct3;
            r_addr_lo   <= bus.req_addr[1:0];
            r_mem_we    <= bus.req_we;
            r_mem_be    <= calc_be(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
            r_mem_addr  <= bus.req_addr[XLEN-1:2];
            r_mem_wdata <= calc_wdata(bus.req_we, bus.req_funct3, bus.req_wdata);
            if (w_req_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state   <= MEM;
              r_mem_req <= 1'b1;
            end
          end
        end
        MEM: begin
          // An ack in the final counted cycle still completes normally.
          if (bus.mem_ack) begin
            r_state      <= RESP;
            r_mem_req    <= 1'b0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_we ? '0 : w_load_data;
          end else if (r_cnt == CNT_LAST) begin
            r_state      <= RESP;
            r_mem_req    <= 1'b0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
